// File: rtl/pipeline_chain.sv
// N-stage pipeline register chain with per-stage valid bits, hold propagation that
// collapses bubbles, ranged flush and a saturating count of flushed entries.
module pipeline_chain #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CNTW  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  input  logic [DEPTH-1:0]           stall_req_i,
  input  logic [DEPTH-1:0]           flush_req_i,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [DEPTH-1:0]           stage_valid_o,
  output logic [DEPTH*WIDTH-1:0]     stage_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [CNTW-1:0]            kill_cnt_o
);
  localparam int OCCW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [CNTW-1:0]             kill_q, kill_d;
  logic [DEPTH-1:0]            hold, killed, src_valid;
  logic [DEPTH-1:0][WIDTH-1:0] src_data;
  logic [OCCW-1:0]             kill_inc, occ;
  logic [CNTW:0]               kill_sum;

  // Walk from the output back: a stage holds if stalled, or if it is occupied and the
  // stage ahead holds. A flush on stage j kills every stage at or below j.
  always_comb begin : hold_kill
    logic h;
    logic f;
    h      = ~out_ready_i;
    f      = 1'b0;
    hold   = '0;
    killed = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      h         = stall_req_i[k] | (valid_q[k] & h);
      f         = f | flush_req_i[k];
      hold[k]   = h;
      killed[k] = f;
    end
  end

  always_comb begin : sources
    src_valid    = '0;
    src_data     = '0;
    src_valid[0] = in_valid_i;
    src_data[0]  = in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      src_valid[k] = valid_q[k-1] & ~hold[k-1] & ~killed[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  always_comb begin : next_state
    valid_d  = valid_q;
    data_d   = data_q;
    kill_inc = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (killed[k]) begin
        valid_d[k] = 1'b0;
        kill_inc   = kill_inc + OCCW'(valid_q[k]);
      end else if (!hold[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) data_d[k] = src_data[k];
      end
    end
    kill_sum = {1'b0, kill_q} + (CNTW+1)'(kill_inc);
    kill_d   = kill_sum[CNTW] ? '1 : kill_sum[CNTW-1:0];
  end

  always_comb begin : popcount
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OCCW'(valid_q[k]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      data_q  <= '0;
      kill_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      kill_q  <= kill_d;
    end
  end

  assign in_ready_o    = ~hold[0];
  assign out_valid_o   = valid_q[DEPTH-1];
  assign out_data_o    = data_q[DEPTH-1];
  assign stage_valid_o = valid_q;
  assign stage_data_o  = data_q;
  assign occupancy_o   = occ;
  assign kill_cnt_o    = kill_q;
endmodule

// File: tb/tb_pipeline_chain.sv
// Directed and random stimulus for pipeline_chain, checked cycle by cycle against a
// slot-array model of the chain plus in-order exit/accept queues.
module tb_pipeline_chain;
  localparam int D = 4;
  localparam int W = 16;
  localparam int C = 8;
  localparam int OW = $clog2(D+1);
  localparam int KMAX = (1 << C) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic [D-1:0]     stall_req;
  logic [D-1:0]     flush_req;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [D-1:0]     stage_valid;
  logic [D*W-1:0]   stage_data;
  logic [OW-1:0]    occupancy;
  logic [C-1:0]     kill_cnt;

  pipeline_chain #(.DEPTH(D), .WIDTH(W), .CNTW(C)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .stall_req_i  (stall_req),
    .flush_req_i  (flush_req),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_ready_i  (out_ready),
    .stage_valid_o(stage_valid),
    .stage_data_o (stage_data),
    .occupancy_o  (occupancy),
    .kill_cnt_o   (kill_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int nstep = 0;

  bit           mv [D];
  logic [W-1:0] md [D];
  int           mkill;
  logic [W-1:0] accq [$];
  logic [W-1:0] exq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < D; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    mkill = 0;
  endtask

  task automatic step(input bit iv, input logic [W-1:0] id, input logic [D-1:0] st,
                      input logic [D-1:0] fl, input bit ordy);
    bit           fr [D+1];
    bit           ov [D];
    logic [W-1:0] od [D];
    int           hi;
    int           kills;
    int           occ;
    logic [D-1:0]   pv;
    logic [D*W-1:0] pd;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    stall_req = st;
    flush_req = fl;
    out_ready = ordy;
    #1;
    // fr[k]: slot k may take a new occupant this cycle
    fr[D] = ordy;
    for (int k = D-1; k >= 0; k--) fr[k] = !st[k] && (!mv[k] || fr[k+1]);
    chk("in_ready", {63'd0, in_ready}, {63'd0, fr[0]});
    chk("out_valid", {63'd0, out_valid}, {63'd0, mv[D-1]});
    chk("out_data", 64'(out_data), 64'(md[D-1]));
    hi = -1;
    for (int k = 0; k < D; k++) if (fl[k]) hi = k;
    kills = 0;
    for (int k = 0; k < D; k++) begin
      ov[k] = mv[k];
      od[k] = md[k];
    end
    if (iv && fr[0] && hi < 0) accq.push_back(id);
    if (ov[D-1] && fr[D-1] && hi < D-1) exq.push_back(od[D-1]);
    for (int k = 0; k < D; k++) begin
      if (k <= hi) begin
        mv[k] = 1'b0;
        if (ov[k]) kills++;
      end else if (fr[k]) begin
        if (k == 0) begin
          mv[0] = iv;
          if (iv) md[0] = id;
        end else begin
          mv[k] = ov[k-1] && fr[k-1] && (k-1 > hi);
          if (mv[k]) md[k] = od[k-1];
        end
      end
    end
    mkill = mkill + kills;
    if (mkill > KMAX) mkill = KMAX;
    @(posedge clk);
    #1;
    nstep++;
    occ = 0;
    for (int k = 0; k < D; k++) begin
      pv[k] = mv[k];
      pd[k*W +: W] = md[k];
      occ += int'(mv[k]);
    end
    chk("stage_valid", 64'(stage_valid), 64'(pv));
    chk("stage_data", 64'(stage_data), 64'(pd));
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("kill_cnt", 64'(kill_cnt), 64'(mkill));
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), '0, '0, ordy);
  endtask

  initial begin
    int first_acc;
    int first_out;
    int kb;
    int nacc;
    logic [W-1:0] abcd [4];

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    stall_req = '0;
    flush_req = '0;
    out_ready = 1'b1;
    model_reset();
    #12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stage_valid", 64'(stage_valid), 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_kill_cnt", 64'(kill_cnt), 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // streaming 1..8 back to back
    accq.delete(); exq.delete();
    first_acc = -1; first_out = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, W'(i), '0, '0, 1'b1);
      if (first_acc < 0 && accq.size() > 0) first_acc = nstep - 1;
      if (first_out < 0 && out_valid === 1'b1) first_out = nstep - 1;
      if (i >= D) chk("t1_occ_full", 64'(occupancy), 64'(D));
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, '0, 1'b1);
      if (first_out < 0 && out_valid === 1'b1) first_out = nstep - 1;
    end
    chk("t1_latency", 64'(first_out - first_acc), 64'(D - 1));
    chk("t1_count", 64'(exq.size()), 64'd8);
    for (int i = 0; i < 8 && i < exq.size(); i++) chk("t1_order", 64'(exq[i]), 64'(i + 1));

    // full chain under back-pressure
    accq.delete(); exq.delete();
    for (int i = 0; i < D; i++) step(1'b1, W'(16'h20 + i), '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h0030, '0, '0, 1'b0);
      chk("t2_in_ready", {63'd0, in_ready}, 64'd0);
      chk("t2_frozen", 64'(out_data), 64'h20);
    end
    idle(6, 1'b1);
    chk("t2_count", 64'(exq.size()), 64'(D));
    for (int i = 0; i < D && i < exq.size(); i++) chk("t2_order", 64'(exq[i]), 64'(16'h20 + i));

    // stall on stage 1 with A..D resident (stage 0 = A)
    abcd[0] = 16'h00AA; abcd[1] = 16'h00BB; abcd[2] = 16'h00CC; abcd[3] = 16'h00DD;
    for (int i = 3; i >= 0; i--) step(1'b1, abcd[i], '0, '0, 1'b0);
    exq.delete();
    step(1'b0, '0, 4'b0010, '0, 1'b1);
    chk("t3_after_stall", 64'(stage_valid), 64'b1011);
    step(1'b0, '0, '0, '0, 1'b1);
    chk("t3_bubble_out", {63'd0, out_valid}, 64'd0);
    idle(4, 1'b1);
    chk("t3_count", 64'(exq.size()), 64'd4);
    for (int i = 0; i < 4 && i < exq.size(); i++) chk("t3_order", 64'(exq[i]), 64'(abcd[3 - i]));

    // flush stages 0..1 on a full chain, with a fresh input that must be dropped
    for (int i = 3; i >= 0; i--) step(1'b1, abcd[i], '0, '0, 1'b0);
    kb = mkill;
    nacc = accq.size();
    step(1'b1, 16'h00EE, '0, 4'b0010, 1'b1);
    chk("t4_valid", 64'(stage_valid), 64'b1000);
    chk("t4_out_data", 64'(out_data), 64'h00CC);
    chk("t4_kill_delta", 64'(kill_cnt), 64'(kb + 2));
    chk("t4_input_dropped", 64'(accq.size()), 64'(nacc));
    idle(3, 1'b1);

    // single item collapses forward against a stalled output
    step(1'b1, 16'h0055, '0, '0, 1'b0);
    for (int i = 0; i < D - 1; i++) begin
      step(1'b0, '0, '0, '0, 1'b0);
      chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
    end
    chk("t5_collapsed", 64'(stage_valid), 64'(1 << (D - 1)));
    for (int i = 0; i < D - 1; i++) step(1'b1, W'(16'h56 + i), '0, '0, 1'b0);
    chk("t5_full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("t5_full_occ", 64'(occupancy), 64'(D));
    idle(5, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [D-1:0] st;
      logic [D-1:0] fl;
      st = ($urandom_range(0, 7) == 0) ? D'(1 << $urandom_range(0, D - 1)) : '0;
      fl = ($urandom_range(0, 15) == 0) ? D'($urandom) : '0;
      step($urandom_range(0, 3) != 0, W'($urandom), st, fl, $urandom_range(0, 3) != 0);
    end

    // asynchronous reset with three items in flight
    idle(5, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h70 + i), '0, '0, 1'b0);
    chk("t6_pre_occ", 64'(occupancy), 64'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(stage_valid), 64'd0);
    chk("t6_async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_async_kill", 64'(kill_cnt), 64'd0);
    chk("t6_async_occ", 64'(occupancy), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_in_ready", {63'd0, in_ready}, 64'd1);

    // saturate the kill counter: one kill every two cycles
    for (int i = 0; i < KMAX + 4; i++) begin
      step(1'b1, W'($urandom), '0, '0, 1'b1);
      step(1'b1, W'($urandom), '0, 4'b0001, 1'b1);
    end
    chk("t6_kill_saturated", 64'(kill_cnt), 64'(KMAX));
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
